// File: rtl/joy_db15_pkg.sv
// Shared DB15 joystick link definitions: state encoding, pad width and button bit positions.
package joy_db15_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DRAIN} db15_state_t;

  localparam int DB15_NBITS = 12;

  // Bit positions within one player's pad word, shared with the console-side reader
  localparam int BTN_R    = 0;
  localparam int BTN_L    = 1;
  localparam int BTN_D    = 2;
  localparam int BTN_U    = 3;
  localparam int BTN_A    = 4;
  localparam int BTN_B    = 5;
  localparam int BTN_C    = 6;
  localparam int BTN_X    = 7;
  localparam int BTN_E    = 8;
  localparam int BTN_F    = 9;
  localparam int BTN_S    = 10;
  localparam int BTN_MODE = 11;

endpackage

// File: rtl/joy_db15_tx_if.sv
// Pad-state inputs and JOY_LOAD/JOY_CLK/JOY_DATA link between the reader side (master) and the emulator (slave).
interface joy_db15_tx_if
  import joy_db15_pkg::*;
#(
  parameter int NBITS = DB15_NBITS
);
  logic [NBITS-1:0] joystick1;
  logic [NBITS-1:0] joystick2;
  logic             JOY_LOAD;
  logic             JOY_CLK;
  logic             JOY_DATA;
  logic             frame_done;
  logic [4:0]       bit_idx;
  logic             overrun;

  modport master (
    output joystick1, joystick2, JOY_LOAD, JOY_CLK,
    input  JOY_DATA, frame_done, bit_idx, overrun
  );

  modport slave (
    input  joystick1, joystick2, JOY_LOAD, JOY_CLK,
    output JOY_DATA, frame_done, bit_idx, overrun
  );
endinterface

// File: rtl/joy_strobe_sync.sv
// Synchroniser for one asynchronous strobe pin, with rise/fall pulses on the synchronised level.
// Optional deglitch filter enabled by defining JOY_DB15_TX_DEGLITCH_EN.
module joy_strobe_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   raw;
  logic                   filt;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  assign raw = sync_q[SYNC_STAGES-1];

`ifdef JOY_DB15_TX_DEGLITCH_EN
  localparam int CW = $clog2(FILT_CYC) + 1;
  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // Down-counter restarts whenever raw agrees; filtered level flips on the FILT_CYC-th disagreeing clk
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b1;
      cnt_q  <= CW'(FILT_CYC - 1);
    end else if (raw == filt_q) begin
      cnt_q <= CW'(FILT_CYC - 1);
    end else if (cnt_q == '0) begin
      filt_q <= raw;
      cnt_q  <= CW'(FILT_CYC - 1);
    end else begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign filt = filt_q;
`else
  localparam int unused_filt_cyc = FILT_CYC;
  assign filt = raw;
`endif

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= filt;
  end

  assign level_o = filt;
  assign rise_o  = filt & ~prev_q;
  assign fall_o  = ~filt & prev_q;
endmodule

// File: rtl/joy_db15_tx.sv
// Device-side DB15 adapter emulator: answers JOY_LOAD/JOY_CLK with a 2*NBITS active-low serial frame.
// Optional strobe deglitch via JOY_DB15_TX_DEGLITCH_EN.
//   state | meaning
//   IDLE  | after reset, JOY_DATA=1 until a load is seen
//   LOAD  | LOAD low, shift reg transparently recaptures pads
//   SHIFT | frame in flight, JOY_CLK rises advance one bit
//   DRAIN | all bits out, JOY_DATA=1, further clocks flag overrun
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int NBITS       = DB15_NBITS,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4
) (
  input logic              clk,
  input logic              reset,
  joy_db15_tx_if.slave     bus
);
  localparam int         NF      = 2 * NBITS;
  localparam logic [4:0] LAST    = 5'(NF - 1);
  localparam logic [4:0] DRAINED = 5'(NF);

  logic load_lvl, load_rise, load_fall;
  logic clk_lvl, clk_rise, clk_fall;
  logic unused_strobes;

  joy_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_load_sync (
    .clk(clk), .reset(reset), .pin_i(bus.JOY_LOAD),
    .level_o(load_lvl), .rise_o(load_rise), .fall_o(load_fall)
  );

  joy_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_clk_sync (
    .clk(clk), .reset(reset), .pin_i(bus.JOY_CLK),
    .level_o(clk_lvl), .rise_o(clk_rise), .fall_o(clk_fall)
  );

  assign unused_strobes = &{1'b0, load_rise, load_fall, clk_lvl, clk_fall};

  db15_state_t    state_q;
  logic [NF-1:0]  shreg_q;
  logic           data_q;
  logic [4:0]     idx_q;
  logic           done_q;
  logic           ovr_q;

  always_ff @(posedge clk) begin
    done_q <= 1'b0;
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '1;
      data_q  <= 1'b1;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else if (!load_lvl) begin
      // Load dominates any clock edge seen in the same cycle
      state_q <= LOAD;
      shreg_q <= {~bus.joystick2, ~bus.joystick1};
      data_q  <= ~bus.joystick1[0];
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        LOAD, SHIFT: begin
          state_q <= SHIFT;
          if (clk_rise) begin
            if (idx_q == LAST) begin
              state_q <= DRAIN;
              shreg_q <= '1;
              data_q  <= 1'b1;
              idx_q   <= DRAINED;
            end else begin
              shreg_q <= {1'b1, shreg_q[NF-1:1]};
              data_q  <= shreg_q[1];
              idx_q   <= idx_q + 5'd1;
              done_q  <= (idx_q + 5'd1 == LAST);
            end
          end
        end
        DRAIN: begin
          if (clk_rise) ovr_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.JOY_DATA   = data_q;
  assign bus.bit_idx    = idx_q;
  assign bus.frame_done = done_q;
  assign bus.overrun    = ovr_q;
endmodule
